// File: rtl/mul_pkg.sv
// Shared constants, state encoding and operand helpers for the 32x32
// sequential shift-add multiplier.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_STEPS = 32;
  localparam int PROD_WIDTH = 2 * MUL_WIDTH;
  localparam int CNT_WIDTH = $clog2(MUL_STEPS);
  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(MUL_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Magnitude of an operand; 0x80000000 maps onto itself, read as unsigned.
  function automatic logic [MUL_WIDTH-1:0] abs_op(input logic [MUL_WIDTH-1:0] v,
                                                  input logic               is_signed);
    abs_op = (is_signed && v[MUL_WIDTH-1]) ? (~v + MUL_WIDTH'(1)) : v;
  endfunction

  function automatic logic [PROD_WIDTH-1:0] neg_prod(input logic [PROD_WIDTH-1:0] v);
    neg_prod = ~v + PROD_WIDTH'(1);
  endfunction

endpackage

// File: rtl/multiplier.sv
// Sequential 32x32 multiplier: one radix-2 shift-add step per cycle on
// operand magnitudes, sign applied once when the product is published.
module multiplier
  import mul_pkg::*;
(
  input  logic                  mul_clk,
  input  logic                  reset,
  input  logic                  mul,
  input  logic                  mul_signed,
  input  logic [MUL_WIDTH-1:0]  x,
  input  logic [MUL_WIDTH-1:0]  y,
  output logic [PROD_WIDTH-1:0] result,
  output logic                  complete,
  output logic                  busy
);

  mul_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PROD_WIDTH-1:0]  mcand_q, mcand_d;
  logic [MUL_WIDTH-1:0]   mplier_q, mplier_d;
  logic                   signed_q, signed_d;
  logic                   sign_q, sign_d;
  logic [PROD_WIDTH-1:0]  acc_q, acc_d;
  logic [PROD_WIDTH-1:0]  result_q, result_d;
  logic                   complete_q, complete_d;
  logic                   busy_q, busy_d;
  logic [PROD_WIDTH-1:0]  acc_step;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    signed_d   = signed_q;
    sign_d     = sign_q;
    acc_d      = acc_q;
    result_d   = result_q;
    // Multiplicand shifts left while the multiplier shifts right, so bit 0
    // of mplier_q is always the bit belonging to the current step.
    acc_step   = acc_q + (mcand_q & {PROD_WIDTH{mplier_q[0]}});

    case (state_q)
      ST_IDLE: begin
        if (mul) begin
          state_d  = ST_BUSY;
          cnt_d    = '0;
          mcand_d  = {{MUL_WIDTH{1'b0}}, abs_op(x, mul_signed)};
          mplier_d = abs_op(y, mul_signed);
          signed_d = mul_signed;
          sign_d   = x[MUL_WIDTH-1] ^ y[MUL_WIDTH-1];
          acc_d    = '0;
        end
      end
      ST_BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == LAST_STEP) begin
          state_d  = ST_DONE;
          // Only the finished product reaches result; partial sums never do.
          result_d = (signed_q && sign_q) ? neg_prod(acc_step) : acc_step;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    complete_d = (state_d == ST_DONE);
  end

  always_ff @(posedge mul_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      signed_q   <= 1'b0;
      sign_q     <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      signed_q   <= signed_d;
      sign_q     <= sign_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      complete_q <= complete_d;
      busy_q     <= busy_d;
    end
  end

  assign result   = result_q;
  assign complete = complete_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: vector table plus hand-written
// sequences for back-to-back, operand toggling and mid-operation reset.
module tb_multiplier;

  logic        mul_clk = 1'b0;
  logic        reset;
  logic        mul;
  logic        mul_signed;
  logic [31:0] x;
  logic [31:0] y;
  logic [63:0] result;
  logic        complete;
  logic        busy;

  multiplier dut (
    .mul_clk    (mul_clk),
    .reset      (reset),
    .mul        (mul),
    .mul_signed (mul_signed),
    .x          (x),
    .y          (y),
    .result     (result),
    .complete   (complete),
    .busy       (busy)
  );

  always #5 mul_clk = ~mul_clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] sb[$];
  logic [63:0] held_val = 64'h0;
  vec_t        vecs[16];

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb_l;
    logic [63:0] ua;
    logic [63:0] ub;
    if (s) begin
      sa   = longint'($signed(a));
      sb_l = longint'($signed(b));
      return 64'(sa * sb_l);
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge mul_clk);
    #1;
  endtask

  // Called at #1 after the accepting edge; returns at #1 into the DONE cycle.
  task automatic wait_done(input string name, input bit toggle);
    int          cyc = 1;
    logic        bad = 1'b0;
    logic [63:0] exp;
    while (complete !== 1'b1 && cyc < 60) begin
      if (result !== held_val || busy !== 1'b1) bad = 1'b1;
      if (toggle) begin
        x          = $urandom;
        y          = $urandom;
        mul_signed = 1'($urandom_range(0, 1));
        mul        = 1'($urandom_range(0, 1));
      end
      step();
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'd33);
    check({name, " hold"}, {63'h0, bad}, 64'h0);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check({name, " result"}, result, exp);
    $display("[TB] %s: s=%0b x=%h y=%h result=%h cycles=%0d", name, mul_signed, x, y, result, cyc);
    held_val = exp;
  endtask

  // Starts and ends at #1 into an IDLE cycle.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string name, input bit toggle);
    mul = 1'b1; mul_signed = s; x = a; y = b;
    step();
    sb.push_back(exp);
    mul = 1'b0;
    wait_done(name, toggle);
    mul = 1'b0;
    step();
    check({name, " idle busy"}, {63'h0, busy}, 64'h0);
  endtask

  initial begin
    int   n;
    logic bad;
    logic saw_c;

    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[2] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
    vecs[5] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 64'h0};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 64'h0};
    for (int i = 8; i < 16; i++) begin
      vecs[i].s   = 1'(i % 2);
      vecs[i].a   = $urandom;
      vecs[i].b   = $urandom;
      vecs[i].exp = model(vecs[i].s, vecs[i].a, vecs[i].b);
    end

    reset = 1'b1; mul = 1'b0; mul_signed = 1'b0; x = '0; y = '0;
    step();
    step();
    check("reset result", result, 64'h0);
    check("reset busy", {63'h0, busy}, 64'h0);
    check("reset complete", {63'h0, complete}, 64'h0);

    // mul is already high in the first cycle after reset drops.
    reset = 1'b0;
    for (int i = 0; i < 16; i++)
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);

    // Back-to-back with mul held high.
    mul = 1'b1; mul_signed = 1'b0; x = 32'd5; y = 32'd6;
    step();
    sb.push_back(64'd30);
    wait_done("b2b first", 1'b0);
    x = 32'd7; y = 32'd8;
    step();
    n = 0; bad = 1'b0;
    while (busy !== 1'b1 && n < 5) begin
      if (result !== 64'd30) bad = 1'b1;
      n++;
      step();
    end
    check("b2b idle gap", 64'(n), 64'd1);
    check("b2b gap hold", {63'h0, bad}, 64'h0);
    sb.push_back(64'd56);
    mul = 1'b0;
    wait_done("b2b second", 1'b0);
    step();

    do_op(1'b0, 32'd12, 32'd12, 64'd144, "toggle", 1'b1);

    // Reset at step 10 of an in-flight operation.
    mul = 1'b1; mul_signed = 1'b0; x = 32'h1234; y = 32'h5678;
    step();
    mul = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset busy", {63'h0, busy}, 64'h0);
    check("midreset result", result, 64'h0);
    saw_c = complete; bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      saw_c |= complete;
      if (result !== 64'h0) bad = 1'b1;
    end
    check("midreset no complete", {63'h0, saw_c}, 64'h0);
    check("midreset result stays 0", {63'h0, bad}, 64'h0);
    held_val = 64'h0;
    do_op(1'b0, 32'd2, 32'd3, 64'd6, "after reset", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 mul_clk  input  1  block clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mul  input  1  multiply command, level-sensitive; sampled only in IDLE; caller drops it after complete unless a new multiply follows.
REQ-006 mul_signed  input  1  1 = two's-complement multiply (MULT), 0 = unsigned (MULTU).
REQ-007 x  input  32  multiplicand.
REQ-008 y  input  32  multiplier.
REQ-009 result  output  64  product; [63:32] -> HI, [31:0] -> LO.
REQ-010 complete  output  1  one-cycle pulse marking the cycle result first holds the new product.
REQ-011 busy  output  1  high in BUSY and DONE, low in IDLE.

Function
REQ-012 The block SHALL implement three states: IDLE, BUSY and DONE.
REQ-013 IDLE with mul=1 at a rising edge SHALL go to BUSY and clear the counter on that edge.
REQ-014 The same edge SHALL latch |x|, |y| (absolute values only when mul_signed=1), mul_signed, and sign = x[31]^y[31].
REQ-015 BUSY SHALL perform one radix-2 shift-add step per cycle on a 64-bit accumulator, for exactly 32 steps, counter 0..31.
REQ-016 Each step SHALL examine one bit of the latched multiplier, LSB first.
REQ-017 After step 31, BUSY SHALL go to DONE.
REQ-018 On the BUSY-to-DONE edge, result SHALL be loaded with the unsigned product, or its two's-complement negation when latched mul_signed=1 and sign=1.
REQ-019 complete SHALL be 1 only in DONE, which lasts exactly one cycle, then return to IDLE.
REQ-020 Latency SHALL be 33 cycles from the accepting edge to the complete cycle.
REQ-021 result SHALL hold its value from the complete cycle until the next BUSY-to-DONE edge; intermediate accumulator values SHALL never appear on result.
REQ-022 mul, x, y and mul_signed SHALL be ignored in BUSY and DONE; operand changes mid-operation SHALL not affect the product.
REQ-023 With mul held high continuously, a new operation SHALL be accepted on the edge ending DONE+1 (the first IDLE cycle), giving one idle cycle between back-to-back operations.
REQ-024 Absolute value of 0x80000000 SHALL be taken as unsigned 0x80000000; no overflow flag SHALL exist.
REQ-025 With zero operands the block SHALL still take the full 33 cycles and produce 0 (no negative zero).

Reset
REQ-026 reset=1 SHALL force IDLE, counter=0, accumulator=0, result=0, complete=0 and busy=0 on the next edge.
REQ-027 Reset SHALL take priority over mul and over any in-flight operation.
REQ-028 A reset mid-BUSY SHALL discard the operation, with no complete pulse.
REQ-029 mul sampled high in the first cycle after reset deasserts SHALL be accepted normally.

Structure
REQ-030 A shared package mul_pkg SHALL hold MUL_WIDTH=32, MUL_STEPS=32 and the IDLE/BUSY/DONE state encoding.
REQ-031 The shift-add datapath, absolute-value logic and negation SHALL be inline; no sub-module is required.

Verification
REQ-032 Unsigned 0xFFFFFFFF x 0xFFFFFFFF SHALL give result=0xFFFFFFFE_00000001, with complete exactly 33 cycles after acceptance.
REQ-033 Signed 0xFFFFFFFF x 0xFFFFFFFF SHALL give 0x00000000_00000001.
REQ-034 Signed -3 x 7 SHALL give 0xFFFFFFFF_FFFFFFEB.
REQ-035 Signed 0x80000000 x 0x80000000 SHALL give 0x40000000_00000000.
REQ-036 Signed 0x80000000 x 1 SHALL give 0xFFFFFFFF_80000000.
REQ-037 Unsigned 0x80000000 x 2 SHALL give 0x00000001_00000000.
REQ-038 mul held high with operands 5x6 then 7x8:
- first complete SHALL show 30;
- result SHALL stay 30 until the second complete, which shows 56;
- exactly one idle cycle SHALL separate the two operations.
REQ-039 Operand toggling during BUSY SHALL not change the product; 12x12 SHALL still give 144.
REQ-040 reset asserted at step 10 of 0x1234 x 0x5678:
- no complete SHALL occur;
- result SHALL be 0;
- a following 2x3 SHALL give 6 after 33 cycles.
